// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter.
// Optional strict priority for requester 0 via I2C_ARB_PRIO0_EN.
package i2c_arb_pkg;

    localparam int DEV_W  = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic              rw;
        logic [DEV_W-1:0]  dev;
        logic [BYTE_W-1:0] addr;
        logic [BYTE_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin selector: first set request bit
// at or after ptr, wrapping around.
module i2c_rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % N_REQ;
            if (req[j]) begin
                idx = IDX_W'(j);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master, with watchdog.
// Define I2C_ARB_PRIO0_EN to give requester 0 strict priority.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ          = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_rw,
    input  logic [7*N_REQ-1:0]   req_dev,
    input  logic [8*N_REQ-1:0]   req_reg,
    input  logic [8*N_REQ-1:0]   req_wdata,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_nack,
    output logic                 rsp_timeout,
    output logic                 m_start,
    output logic                 m_rw,
    output logic [6:0]           m_dev,
    output logic [7:0]           m_reg,
    output logic [7:0]           m_wdata,
    output logic                 m_abort,
    input  logic                 m_done,
    input  logic                 m_nack,
    input  logic [7:0]           m_rdata,
    output logic                 busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  wd_q, wd_d;
    cmd_t              cmd_q, cmd_d;
    logic [BYTE_W-1:0] rdata_q, rdata_d;
    logic              nack_q, nack_d;
    logic              timeout_q, timeout_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  sel_idx;

    i2c_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef I2C_ARB_PRIO0_EN
    assign sel_idx = req_valid[0] ? '0 : pick_idx;
`else
    assign sel_idx = pick_idx;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        wd_d      = wd_q;
        cmd_d     = cmd_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        timeout_d = timeout_q;
        req_ready = '0;
        rsp_valid = '0;
        m_start   = 1'b0;
        m_abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    cmd_d.rw    = req_rw[sel_idx];
                    cmd_d.dev   = req_dev[int'(sel_idx)*DEV_W +: DEV_W];
                    cmd_d.addr  = req_reg[int'(sel_idx)*BYTE_W +: BYTE_W];
                    cmd_d.wdata = req_wdata[int'(sel_idx)*BYTE_W +: BYTE_W];
                    owner_d     = sel_idx;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                req_ready[owner_q] = 1'b1;
                m_start            = 1'b1;
                wd_d               = '0;
`ifdef I2C_ARB_PRIO0_EN
                if (owner_q != '0) begin
                    rr_ptr_d = (owner_q == LAST) ? '0 : owner_q + IDX_W'(1);
                end
`else
                rr_ptr_d = (owner_q == LAST) ? '0 : owner_q + IDX_W'(1);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + CNT_W'(1);
                // A completion in the expiry cycle beats the abort.
                if (m_done) begin
                    rdata_d   = m_rdata;
                    nack_d    = m_nack;
                    timeout_d = 1'b0;
                    state_d   = RESP;
                end else if (wd_q == WD_LIMIT) begin
                    m_abort   = 1'b1;
                    rdata_d   = '0;
                    nack_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            wd_q      <= '0;
            cmd_q     <= '0;
            rdata_q   <= '0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            cmd_q     <= cmd_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
        end
    end

    assign m_rw        = cmd_q.rw;
    assign m_dev       = cmd_q.dev;
    assign m_reg       = cmd_q.addr;
    assign m_wdata     = cmd_q.wdata;
    assign rsp_rdata   = rdata_q;
    assign rsp_nack    = nack_q;
    assign rsp_timeout = timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed self-checking bench for i2c_txn_arbiter (N_REQ=3).
// Priority scenario compiled in with I2C_ARB_PRIO0_EN.
module tb_i2c_txn_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_rw;
    logic [20:0] req_dev;
    logic [23:0] req_reg;
    logic [23:0] req_wdata;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;
    logic        m_start;
    logic        m_rw;
    logic [6:0]  m_dev;
    logic [7:0]  m_reg;
    logic [7:0]  m_wdata;
    logic        m_abort;
    logic        m_done;
    logic        m_nack;
    logic [7:0]  m_rdata;
    logic        busy;

    int tests;
    int fails;

    i2c_txn_arbiter #(
        .N_REQ          (3),
        .TIMEOUT_CYCLES (4096),
        .CNT_W          (13)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rw      (req_rw),
        .req_dev     (req_dev),
        .req_reg     (req_reg),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_nack    (rsp_nack),
        .rsp_timeout (rsp_timeout),
        .m_start     (m_start),
        .m_rw        (m_rw),
        .m_dev       (m_dev),
        .m_reg       (m_reg),
        .m_wdata     (m_wdata),
        .m_abort     (m_abort),
        .m_done      (m_done),
        .m_nack      (m_nack),
        .m_rdata     (m_rdata),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw,
                           input logic [6:0] dev,
                           input logic [7:0] r,
                           input logic [7:0] wd);
        req_rw[i]          = rw;
        req_dev[i*7 +: 7]  = dev;
        req_reg[i*8 +: 8]  = r;
        req_wdata[i*8 +: 8] = wd;
    endtask

    // Advance until m_start is seen, bounded; n = cycles advanced.
    task automatic wait_start(output int n);
        n = 0;
        while (m_start !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
             m_start, m_rw, m_dev, m_reg, m_wdata, m_abort, busy} !== '0)
            begin
            fails++;
            $display("FAIL reset_outputs: got nonzero busy=%b m_dev=%h",
                     busy, m_dev);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (busy !== 1'b0 || req_ready !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle: busy=%b req_ready=%b want 0",
                     busy, req_ready);
        end
    endtask

    task automatic test_single_write();
        set_req(1, 1'b0, 7'h1A, 8'h02, 8'h55);
        req_valid = 3'b010;
        tests++;
        if (req_ready !== 3'b000 || m_start !== 1'b0) begin
            fails++;
            $display("FAIL single_pre: req_ready=%b m_start=%b want 0",
                     req_ready, m_start);
        end
        tick();
        tests++;
        if (req_ready !== 3'b010 || m_start !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: req_ready=%b m_start=%b want 010/1",
                     req_ready, m_start);
        end
        tests++;
        if (m_dev !== 7'h1A || m_reg !== 8'h02 ||
            m_wdata !== 8'h55 || m_rw !== 1'b0) begin
            fails++;
            $display("FAIL single_cmd: dev=%h reg=%h wd=%h rw=%b",
                     m_dev, m_reg, m_wdata, m_rw);
        end
        req_valid = 3'b000;
        repeat (20) tick();
        tests++;
        if (rsp_valid !== 3'b000 || m_abort !== 1'b0 ||
            busy !== 1'b1 || m_dev !== 7'h1A) begin
            fails++;
            $display("FAIL single_wait: rsp=%b abort=%b busy=%b dev=%h",
                     rsp_valid, m_abort, busy, m_dev);
        end
        m_done  = 1'b1;
        m_nack  = 1'b0;
        m_rdata = 8'hAA;
        tick();
        m_done = 1'b0;
        tests++;
        if (rsp_valid !== 3'b010 || rsp_nack !== 1'b0 ||
            rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL single_rsp: rsp=%b nack=%b to=%b want 010/0/0",
                     rsp_valid, rsp_nack, rsp_timeout);
        end
        tick();
        tests++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_end: rsp=%b busy=%b want 0/0",
                     rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_q [4];
        exp_q = '{2'd0, 2'd1, 2'd2, 2'd0};
        set_req(0, 1'b0, 7'h10, 8'h00, 8'h01);
        set_req(1, 1'b0, 7'h11, 8'h01, 8'h02);
        set_req(2, 1'b0, 7'h12, 8'h02, 8'h03);
        rst       = 1'b1;
        req_valid = 3'b111;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_start(n);
            tests++;
            if (m_start !== 1'b1 || n != 1 ||
                req_ready !== (3'b001 << exp_q[k])) begin
                fails++;
                $display("FAIL rr_grant%0d: ready=%b n=%0d want %b n=1",
                         k, req_ready, n, 3'b001 << exp_q[k]);
            end
            req_valid[exp_q[k]] = 1'b0;
            tick();
            repeat (3) tick();
            tests++;
            if (req_ready !== 3'b000 || busy !== 1'b1) begin
                fails++;
                $display("FAIL rr_hold%0d: ready=%b busy=%b want 000/1",
                         k, req_ready, busy);
            end
            m_done  = 1'b1;
            m_rdata = 8'h00;
            tick();
            m_done = 1'b0;
            tests++;
            if (rsp_valid !== (3'b001 << exp_q[k])) begin
                fails++;
                $display("FAIL rr_rsp%0d: rsp=%b want %b",
                         k, rsp_valid, 3'b001 << exp_q[k]);
            end
            if (k == 3) req_valid = 3'b000;
            tick();
            if (k < 3) req_valid[exp_q[k]] = 1'b1;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_read_nack();
        int n;
        set_req(2, 1'b1, 7'h50, 8'h10, 8'hFF);
        req_valid = 3'b100;
        wait_start(n);
        tests++;
        if (req_ready !== 3'b100 || m_rw !== 1'b1 || m_dev !== 7'h50) begin
            fails++;
            $display("FAIL rd_grant: ready=%b rw=%b dev=%h",
                     req_ready, m_rw, m_dev);
        end
        req_valid = 3'b000;
        repeat (6) tick();
        m_done  = 1'b1;
        m_nack  = 1'b1;
        m_rdata = 8'hC3;
        tick();
        m_done = 1'b0;
        m_nack = 1'b0;
        tests++;
        if (rsp_valid !== 3'b100 || rsp_rdata !== 8'hC3 ||
            rsp_nack !== 1'b1 || rsp_timeout !== 1'b0) begin
            fails++;
            $display("FAIL rd_rsp: rsp=%b rd=%h nack=%b to=%b",
                     rsp_valid, rsp_rdata, rsp_nack, rsp_timeout);
        end
        tick();
        tests++;
        if (rsp_rdata !== 8'hC3 || rsp_nack !== 1'b1 ||
            rsp_valid !== 3'b000) begin
            fails++;
            $display("FAIL rd_hold: rd=%h nack=%b rsp=%b want C3/1/000",
                     rsp_rdata, rsp_nack, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit early;
        early = 1'b0;
        set_req(0, 1'b0, 7'h21, 8'h05, 8'h66);
        set_req(1, 1'b1, 7'h22, 8'h06, 8'h00);
        req_valid = 3'b001;
        wait_start(n);
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("FAIL to_grant: ready=%b want 001", req_ready);
        end
        req_valid = 3'b010;
        for (int k = 1; k < 4096; k++) begin
            tick();
            if (m_abort !== 1'b0 || rsp_valid !== 3'b000) early = 1'b1;
        end
        tests++;
        if (early) begin
            fails++;
            $display("FAIL to_early: abort/rsp seen before 4096, want none");
        end
        tick();
        tests++;
        if (m_abort !== 1'b1) begin
            fails++;
            $display("FAIL to_abort: m_abort=%b at 4096, want 1", m_abort);
        end
        tick();
        tests++;
        if (rsp_valid !== 3'b001 || rsp_timeout !== 1'b1 ||
            rsp_rdata !== 8'h00 || rsp_nack !== 1'b0 ||
            m_abort !== 1'b0) begin
            fails++;
            $display("FAIL to_rsp: rsp=%b to=%b rd=%h nack=%b ab=%b",
                     rsp_valid, rsp_timeout, rsp_rdata, rsp_nack, m_abort);
        end
        wait_start(n);
        tests++;
        if (req_ready !== 3'b010 || n != 2) begin
            fails++;
            $display("FAIL to_next: ready=%b n=%0d want 010 n=2",
                     req_ready, n);
        end
        req_valid = 3'b000;
        tick();
        m_done  = 1'b1;
        m_rdata = 8'h5A;
        tick();
        m_done = 1'b0;
        tests++;
        if (rsp_valid !== 3'b010 || rsp_timeout !== 1'b0 ||
            rsp_rdata !== 8'h5A) begin
            fails++;
            $display("FAIL to_after: rsp=%b to=%b rd=%h want 010/0/5A",
                     rsp_valid, rsp_timeout, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_done_at_timeout();
        int n;
        set_req(2, 1'b1, 7'h33, 8'h44, 8'h00);
        req_valid = 3'b100;
        wait_start(n);
        req_valid = 3'b000;
        repeat (4095) tick();
        tests++;
        if (m_abort !== 1'b0) begin
            fails++;
            $display("FAIL same_pre: m_abort=%b at 4095, want 0", m_abort);
        end
        tick();
        m_done  = 1'b1;
        m_nack  = 1'b1;
        m_rdata = 8'h7E;
        #1;
        tests++;
        if (m_abort !== 1'b0) begin
            fails++;
            $display("FAIL same_abort: m_abort=%b with m_done, want 0",
                     m_abort);
        end
        tick();
        m_done = 1'b0;
        m_nack = 1'b0;
        tests++;
        if (rsp_valid !== 3'b100 || rsp_timeout !== 1'b0 ||
            rsp_rdata !== 8'h7E || rsp_nack !== 1'b1) begin
            fails++;
            $display("FAIL same_rsp: rsp=%b to=%b rd=%h nack=%b",
                     rsp_valid, rsp_timeout, rsp_rdata, rsp_nack);
        end
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tests++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_done: rsp=%b busy=%b want 000/0",
                     rsp_valid, busy);
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit seen;
        seen = 1'b0;
        set_req(1, 1'b1, 7'h3C, 8'h9A, 8'h11);
        req_valid = 3'b010;
        wait_start(n);
        req_valid = 3'b000;
        repeat (2) tick();
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
             m_start, m_rw, m_dev, m_reg, m_wdata, m_abort, busy} !== '0)
            begin
            fails++;
            $display("FAIL async_rst: busy=%b dev=%h reg=%h want all 0",
                     busy, m_dev, m_reg);
        end
        tick();
        rst    = 1'b0;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        repeat (3) begin
            if (rsp_valid !== 3'b000 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL async_drop: response or busy after reset");
        end
    endtask

`ifdef I2C_ARB_PRIO0_EN
    task automatic test_prio0();
        int n;
        do_reset();
        set_req(0, 1'b0, 7'h01, 8'h01, 8'h01);
        set_req(1, 1'b0, 7'h02, 8'h02, 8'h02);
        set_req(2, 1'b0, 7'h03, 8'h03, 8'h03);
        req_valid = 3'b110;
        wait_start(n);
        tests++;
        if (req_ready !== 3'b010) begin
            fails++;
            $display("FAIL prio_first: ready=%b want 010", req_ready);
        end
        req_valid = 3'b100;
        tick();
        req_valid = 3'b101;
        repeat (2) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        wait_start(n);
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("FAIL prio_zero: ready=%b want 001", req_ready);
        end
        req_valid = 3'b100;
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        wait_start(n);
        tests++;
        if (req_ready !== 3'b100) begin
            fails++;
            $display("FAIL prio_two: ready=%b want 100", req_ready);
        end
        req_valid = 3'b000;
        tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_rw    = '0;
        req_dev   = '0;
        req_reg   = '0;
        req_wdata = '0;
        m_done    = 1'b0;
        m_nack    = 1'b0;
        m_rdata   = '0;
        #2;
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_nack();
        test_timeout();
        test_done_at_timeout();
        test_async_reset();
`ifdef I2C_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
